// File: rtl/kara_pkg.sv
// Shared width helpers and default sizes for the pipelined Karatsuba multiplier.
package kara_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_TAG_W  = 4;

  function automatic int half_w(input int data_w);
    return data_w / 2;
  endfunction

  // Karatsuba middle term p3 - p1 - p2 is non-negative and needs one extra bit.
  function automatic int mid_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/kara_abs_split.sv
// Sign stripping and half-splitting front end: magnitudes of A/B cut into halves plus half sums.
module kara_abs_split
  import kara_pkg::*;
#(
  parameter int   DATA_W = DEFAULT_DATA_W,
  localparam int  H      = half_w(DATA_W)
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              is_signed,
  output logic [H-1:0]      ah,
  output logic [H-1:0]      al,
  output logic [H-1:0]      bh,
  output logic [H-1:0]      bl,
  output logic [H:0]        sa,
  output logic [H:0]        sb,
  output logic              neg
);

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;

  // Negating the most-negative value wraps back to 2^(DATA_W-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (is_signed && a[DATA_W-1]) ? -a : a;
    mag_b = (is_signed && b[DATA_W-1]) ? -b : b;
  end

  assign ah  = mag_a[DATA_W-1:H];
  assign al  = mag_a[H-1:0];
  assign bh  = mag_b[DATA_W-1:H];
  assign bl  = mag_b[H-1:0];
  assign sa  = {1'b0, ah} + {1'b0, al};
  assign sb  = {1'b0, bh} + {1'b0, bl};
  assign neg = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);

endmodule

// File: rtl/multiplier_kara_pipe.sv
// Three-stage Karatsuba multiplier (split, partial products, combine) with a
// single global stall driven by output backpressure.
module multiplier_kara_pipe
  import kara_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int TAG_W  = DEFAULT_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic [2*DATA_W-1:0] S
);

  localparam int H  = half_w(DATA_W);
  localparam int MW = mid_w(DATA_W);
  localparam int PW = MW + 1;

  if ((DATA_W % 2) != 0 || DATA_W < 4) begin : g_bad_width
    $error("multiplier_kara_pipe: DATA_W must be even and >= 4");
  end

  typedef struct packed {
    logic [H-1:0]     ah;
    logic [H-1:0]     al;
    logic [H-1:0]     bh;
    logic [H-1:0]     bl;
    logic [H:0]       sa;
    logic [H:0]       sb;
    logic             neg;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic             v1, v2, v3;
  logic             stall;
  s1_t              s1_d, s1_q;
  logic [H-1:0]     ah_w, al_w, bh_w, bl_w;
  logic [H:0]       sa_w, sb_w;
  logic             neg_w;
  logic [DATA_W-1:0] p1, p2;
  logic [PW-1:0]    p3;
  logic             neg2;
  logic [TAG_W-1:0] tag2;
  logic [PW-1:0]    mid_full;
  logic [2*DATA_W-1:0] mag, result;

  assign stall     = v3 && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v3;

  kara_abs_split #(.DATA_W(DATA_W)) u_split (
    .a         (A),
    .b         (B),
    .is_signed (in_signed),
    .ah        (ah_w),
    .al        (al_w),
    .bh        (bh_w),
    .bl        (bl_w),
    .sa        (sa_w),
    .sb        (sb_w),
    .neg       (neg_w)
  );

  always_comb begin
    s1_d     = '0;
    s1_d.ah  = ah_w;
    s1_d.al  = al_w;
    s1_d.bh  = bh_w;
    s1_d.bl  = bl_w;
    s1_d.sa  = sa_w;
    s1_d.sb  = sb_w;
    s1_d.neg = neg_w;
    s1_d.tag = in_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_q <= s1_d;
      p1   <= {{H{1'b0}}, s1_q.ah} * {{H{1'b0}}, s1_q.bh};
      p2   <= {{H{1'b0}}, s1_q.al} * {{H{1'b0}}, s1_q.bl};
      p3   <= {{(H+1){1'b0}}, s1_q.sa} * {{(H+1){1'b0}}, s1_q.sb};
      neg2 <= s1_q.neg;
      tag2 <= s1_q.tag;
    end
  end

  // Top bit of mid_full is always zero; the true middle term fits MW bits.
  always_comb begin
    mid_full = p3 - {2'b00, p1} - {2'b00, p2};
    mag      = {p1, {DATA_W{1'b0}}}
             + ({{(2*DATA_W-PW){1'b0}}, mid_full} << H)
             + {{DATA_W{1'b0}}, p2};
    result   = neg2 ? -mag : mag;
  end

  // Only capture real results so S keeps its reset/last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S       <= '0;
      out_tag <= '0;
    end else if (!stall && v2) begin
      S       <= result;
      out_tag <= tag2;
    end
  end

endmodule
